// File: rtl/beat_packer_pkg.sv
// beat_packer_pkg: shared FSM state type and default geometry for the beat packer.
package beat_packer_pkg;
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;
    localparam int DW_DEF = 3;
    localparam int N_DEF  = 4;
endpackage

// File: rtl/beat_packer.sv
// beat_packer: packs N upstream beats of DW bits into one word, with flush for partial words.
// Ports: sys_clk/sys_rst (sync active-high); valid_up/data_up/ready_up upstream beat handshake;
// flush emits a partial word; valid_down/data_down/cnt_down/ready_down downstream word handshake.
module beat_packer
    import beat_packer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       valid_up,
    input  logic [DW-1:0]              data_up,
    output logic                       ready_up,
    input  logic                       flush,
    output logic                       valid_down,
    output logic [N*DW-1:0]            data_down,
    output logic [$clog2(N+1)-1:0]     cnt_down,
    input  logic                       ready_down
);
    localparam int CW = $clog2(N + 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("beat_packer: N must be in 2..8");
    end

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, slot_sel;
    logic [N-1:0][DW-1:0]   slots_q, slots_d;
    logic                   beat, word;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            slots_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
        end
    end

    // A full slot set or a flush with at least one beat (held or arriving now) closes the word.
    always_comb begin
        state_d = state_q;
        if (state_q == FILL) begin
            if ((beat && cnt_q == CW'(N - 1)) || (flush && (beat || cnt_q != '0)))
                state_d = HOLD;
        end else if (word) begin
            state_d = FILL;
        end
    end

    // A beat accepted in HOLD always coincides with a word transfer, so it lands in slot 0.
    always_comb begin
        slots_d  = slots_q;
        cnt_d    = cnt_q;
        slot_sel = word ? '0 : cnt_q;
        if (word) begin
            slots_d = '0;
            cnt_d   = '0;
        end
        if (beat) begin
            for (int k = 0; k < N; k++)
                if (slot_sel == CW'(k)) slots_d[k] = data_up;
            cnt_d = word ? CW'(1) : cnt_q + CW'(1);
        end
    end

    assign valid_down = state_q == HOLD;
    assign ready_up   = (state_q == FILL) || ready_down;
    assign beat       = valid_up && ready_up;
    assign word       = valid_down && ready_down;
    assign data_down  = slots_q;
    assign cnt_down   = valid_down ? cnt_q : '0;
endmodule

// File: doc/beat_packer.md
BEAT_PACKER -- requirements
Module: beat_packer

Interface
REQ-001 Parameter DW, default 3, upstream beat width in bits.
REQ-002 Parameter N, default 4, beats per packed word; legal range 2..8.
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset; synchronous, active-high.
REQ-005 valid_up  input  1  upstream beat valid, driven by the preceding pipe stage's valid_down.
REQ-006 data_up  input  DW  upstream beat data.
REQ-007 ready_up  output  1  packer can accept a beat this cycle.
REQ-008 flush  input  1  request to emit a partially filled word.
REQ-009 valid_down  output  1  packed word valid.
REQ-010 data_down  output  N*DW  packed word; beat k in bits [k*DW+DW-1 : k*DW].
REQ-011 cnt_down  output  clog2(N+1)  number of real beats in data_down, 1..N.
REQ-012 ready_down  input  1  consumer accepts the word.

Function
REQ-013 Beat transfer occurs when valid_up && ready_up at a clock edge; word transfer when valid_down && ready_down.
REQ-014 States: FILL (collecting, valid_down=0) and HOLD (word presented, valid_down=1).
REQ-015 Slot counter cnt, 0..N-1 in FILL; an accepted beat writes slot cnt, then cnt increments.
REQ-016 FILL: ready_up=1; accepting the beat that fills slot N-1 -> HOLD next cycle with cnt_down=N.
REQ-017 FILL, flush=1, cnt>0, no beat accepted -> HOLD with cnt_down=cnt; unfilled slots read 0.
REQ-018 FILL, flush=1 and beat accepted same cycle -> beat included, then HOLD with cnt_down=cnt+1 (or N if filled).
REQ-019 FILL, flush=1, cnt=0, no beat -> no effect; no empty words ever emitted.
REQ-020 HOLD: ready_up=ready_down (combinational); data_down and cnt_down stable while valid_down=1 and ready_down=0.
REQ-021 HOLD, word transfer without beat -> FILL, cnt=0, all slots cleared to 0.
REQ-022 HOLD, word transfer with beat -> beat written to slot 0, cnt=1, FILL (zero bubble).
REQ-023 flush in HOLD ignored; flush is level-sensitive, not latched.
REQ-024 Latency: last beat accepted at edge t -> valid_down=1 from t+1; throughput one beat per cycle sustained when ready_down=1.
REQ-025 data_up ignored when no beat transfer; valid_up may drop without transfer.
REQ-026 N=1 edge not supported; elaboration error if N<2.

Reset
REQ-027 sys_rst=1 at an edge -> state FILL, cnt=0, slots=0, valid_down=0, cnt_down=0, data_down=0.
REQ-028 Reset mid-word or in HOLD discards partial/pending data; no transfer reported in the reset cycle.
REQ-029 ready_up=1 the first cycle after reset deasserts.

Structure
REQ-030 Shared package beat_packer_pkg holds state enum (FILL, HOLD) and defaults DW_DEF=3, N_DEF=4.
REQ-031 Single module; no sub-module (slot register array + counter + 2-state FSM inline).

Verification
REQ-032 Beats 1,2,3,4 back-to-back, ready_down=1 -> data_down=12'o4321, cnt_down=4, valid_down one cycle after 4th beat.
REQ-033 Beats 5,6 then flush with valid_up=0 -> data_down=12'o0065, cnt_down=2.
REQ-034 Full word held, ready_down=0 for 5 cycles -> ready_up=0, data_down stable; release with valid_up=1 data 7 -> next word slot 0 =7, no bubble.
REQ-035 Continuous random beats, ready_down toggling 50% -> scoreboard: every beat appears once, in order, no loss/duplication.
REQ-036 sys_rst pulsed after 2 beats -> valid_down=0, next 4 beats 1,1,1,1 produce 12'o1111 with cnt_down=4.
REQ-037 flush with cnt=0 for 3 cycles -> valid_down stays 0.
